// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the key debounce bank.
//   - KEY_ACTIVE_LOW_DEF : default pin polarity (1 = pin reads 0 when pressed)
//   - *_DEF              : default tick divider, stability and repeat settings
//   - cnt_width()        : bit width of a counter that holds 0..n_states-1
// Optional feature macro used by the bank: KEY_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
package key_pkg;

   localparam int N_KEYS_DEF         = 5;
   localparam int KEY_ACTIVE_LOW_DEF = 1;
   localparam int TICK_DIV_DEF       = 500000;
   localparam int STABLE_CNT_DEF     = 3;
   localparam int HOLD_TICKS_DEF     = 50;
   localparam int REPEAT_TICKS_DEF   = 10;

   // Never returns 0 so a counter with a single state still gets a real bit.
   function automatic int cnt_width(input int n_states);
      return (n_states <= 2) ? 1 : $clog2(n_states);
   endfunction

endpackage

// File: rtl/key_tick_gen.sv
// -----------------------------------------------------------------------------
// key_tick_gen
// Free-running divider producing a one-clk sample strobe every TICK_DIV clocks.
// The first strobe appears in the TICK_DIV-th cycle after reset release.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   tick out  high for one clk when the counter sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module key_tick_gen
   import key_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W = cnt_width(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   if (TICK_DIV < 2) begin : g_param_err
      $error("key_tick_gen: TICK_DIV must be >= 2");
   end

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/key_debounce_bank.sv
// -----------------------------------------------------------------------------
// key_debounce_bank
// Multi-channel push-button conditioner: 2-flop synchroniser, tick-sampled
// debounce, press/release pulses and a press-toggled latch per key.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat key_press while held).
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   key          in   raw button pins, N_KEYS wide
//   key_level    out  debounced state, 1 = pressed
//   key_press    out  one-clk pulse on accepted press (and on repeats)
//   key_release  out  one-clk pulse on accepted release
//   key_toggle   out  flips on every genuine press
// -----------------------------------------------------------------------------
module key_debounce_bank
   import key_pkg::*;
#(
   parameter int N_KEYS         = N_KEYS_DEF,
   parameter int TICK_DIV       = TICK_DIV_DEF,
   parameter int STABLE_CNT     = STABLE_CNT_DEF,
   parameter int KEY_ACTIVE_LOW = KEY_ACTIVE_LOW_DEF,
   parameter int HOLD_TICKS     = HOLD_TICKS_DEF,
   parameter int REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_toggle
);

   localparam int                STB_W    = cnt_width(STABLE_CNT);
   localparam logic [STB_W-1:0]  STB_LAST = STB_W'(STABLE_CNT - 1);
   localparam logic              POL_LOW  = (KEY_ACTIVE_LOW != 0);
   // Pin level meaning "released", used to preset the synchroniser.
   localparam logic [N_KEYS-1:0] INACTIVE = {N_KEYS{POL_LOW}};

   if (N_KEYS < 1 || TICK_DIV < 2 || STABLE_CNT < 1 || HOLD_TICKS < 1 ||
       REPEAT_TICKS < 1 || (KEY_ACTIVE_LOW != 0 && KEY_ACTIVE_LOW != 1)) begin : g_param_err
      $error("key_debounce_bank: illegal parameter value");
   end

   logic w_tick;

   key_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   logic [N_KEYS-1:0] r_sync1;
   logic [N_KEYS-1:0] r_sync2;
   logic [N_KEYS-1:0] w_sample;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= INACTIVE;
         r_sync2 <= INACTIVE;
      end else begin
         r_sync1 <= key;
         r_sync2 <= r_sync1;
      end
   end

   // Normalised so 1 always means pressed.
   assign w_sample = POL_LOW ? ~r_sync2 : r_sync2;

   genvar gi;
   for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
      logic [STB_W-1:0] r_stb;
      logic             r_level;
      logic             r_level_d;
      logic             r_press;
      logic             r_release;
      logic             r_toggle;
      logic             w_rise;
      logic             w_fall;
      logic             w_rep_fire;

      // Debounce: count consecutive disagreeing ticks, accept on the last one.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_stb   <= '0;
            r_level <= 1'b0;
         end else if (w_tick) begin
            if (w_sample[gi] == r_level) begin
               r_stb <= '0;
            end else if (r_stb == STB_LAST) begin
               r_level <= w_sample[gi];
               r_stb   <= '0;
            end else begin
               r_stb <= r_stb + 1'b1;
            end
         end
      end

      // Edges are detected against a delayed copy, so pulses land one clk
      // after key_level moves.
      assign w_rise = r_level & ~r_level_d;
      assign w_fall = ~r_level & r_level_d;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
         end else begin
            r_level_d <= r_level;
            r_press   <= w_rise | w_rep_fire;
            r_release <= w_fall;
            if (w_rise) begin
               r_toggle <= ~r_toggle;
            end
         end
      end

`ifdef KEY_AUTOREPEAT_EN
      localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
      localparam int HOLD_W   = cnt_width(HOLD_MAX);

      logic [HOLD_W-1:0] r_hold;
      logic              r_rep_phase;   // 0: waiting for first repeat, 1: repeating
      logic              w_hold_last;

      assign w_hold_last = r_rep_phase ? (r_hold == HOLD_W'(REPEAT_TICKS - 1))
                                       : (r_hold == HOLD_W'(HOLD_TICKS - 1));
      assign w_rep_fire  = w_tick & r_level & w_hold_last;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_hold      <= '0;
            r_rep_phase <= 1'b0;
         end else if (w_tick) begin
            if (!r_level) begin
               r_hold      <= '0;
               r_rep_phase <= 1'b0;
            end else if (w_hold_last) begin
               r_hold      <= '0;
               r_rep_phase <= 1'b1;
            end else begin
               r_hold <= r_hold + 1'b1;
            end
         end
      end
`else
      assign w_rep_fire = 1'b0;
`endif

      assign key_level[gi]   = r_level;
      assign key_press[gi]   = r_press;
      assign key_release[gi] = r_release;
      assign key_toggle[gi]  = r_toggle;
   end

endmodule
